// File: rtl/cii_table_ctrl.sv
// cii_table_ctrl: COLS x ROWS character table written from a keyboard stream, read by a display scanner.
// Define CII_CURSOR_EN to show '_' at the write cursor when that cell is blank.
module cii_table_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] char_x_rd,
  input  logic [4:0] char_y_rd,
  input  logic       rd_vld,
  input  logic       we_vld,
  input  logic [7:0] ascii_i,
  output logic [7:0] ascii_o
);
  localparam int N = COLS * ROWS;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t      state;
  logic [7:0]  mem [N];
  logic [11:0] clr_addr;
  logic [6:0]  cx, cx_fw, cx_bk;
  logic [4:0]  cy, cy_fw, cy_bk;
  logic        we_d, ev, printable, is_nl, is_bs;
  logic        wr_en, rd_in;
  logic [11:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_byte, rd_data;
  assign ev        = state == RUN && we_vld && !we_d;
  assign printable = ascii_i >= 8'h20 && ascii_i <= 8'h7E;
  assign is_nl     = ascii_i == 8'h0D || ascii_i == 8'h0A;
  assign is_bs     = ascii_i == 8'h08;
  always_comb begin
    cx_fw   = cx == 7'(COLS - 1) ? 7'd0 : cx + 7'd1;
    cx_bk   = cx == 7'd0 ? 7'(COLS - 1) : cx - 7'd1;
    cy_fw   = cy == 5'(ROWS - 1) ? 5'd0 : cy + 5'd1;
    cy_bk   = cy == 5'd0 ? 5'(ROWS - 1) : cy - 5'd1;
    wr_en   = state == CLEAR || (ev && (printable || is_bs));
    wr_addr = state == CLEAR ? clr_addr :
              is_bs ? 12'(cx == 7'd0 ? cy_bk : cy) * 12'(COLS) + 12'(cx_bk) :
              12'(cy) * 12'(COLS) + 12'(cx);
    wr_data = state == CLEAR ? 8'h00 : is_bs ? 8'h20 : ascii_i;
    rd_in   = char_x_rd < 7'(COLS) && char_y_rd < 5'(ROWS);
    rd_addr = 12'(char_y_rd) * 12'(COLS) + 12'(char_x_rd);
    rd_byte = rd_in ? mem[rd_addr] : 8'h00;
`ifdef CII_CURSOR_EN
    rd_data = rd_in && char_x_rd == cx && char_y_rd == cy &&
              (rd_byte == 8'h00 || rd_byte == 8'h20) ? 8'h5F : rd_byte;
`else
    rd_data = rd_byte;
`endif
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= CLEAR;
      clr_addr <= 12'd0;
      cx       <= 7'd0;
      cy       <= 5'd0;
      we_d     <= 1'b0;
      ascii_o  <= 8'h00;
    end else begin
      we_d <= we_vld;
      // only a definite 0 holds the output; X/Z falls through to the update
      if (rd_vld == 1'b0) ascii_o <= ascii_o;
      else ascii_o <= state == CLEAR ? 8'h00 : rd_data;
      if (state == CLEAR) begin
        clr_addr <= clr_addr + 12'd1;
        if (clr_addr == 12'(N - 1)) state <= RUN;
      end else if (ev) begin
        if (printable) begin
          cx <= cx_fw;
          if (cx == 7'(COLS - 1)) cy <= cy_fw;
        end else if (is_nl) begin
          cx <= 7'd0;
          cy <= cy_fw;
        end else if (is_bs) begin
          cx <= cx_bk;
          if (cx == 7'd0) cy <= cy_bk;
        end
      end
    end
  end
endmodule

// File: tb/tb_cii_table_ctrl.sv
// tb_cii_table_ctrl: table-driven read checks of cii_table_ctrl after scripted keyboard sequences.
module tb_cii_table_ctrl;
  logic       clk = 0, rstn = 0, rd_vld = 1, we_vld = 0;
  logic [6:0] char_x_rd = 0;
  logic [4:0] char_y_rd = 0;
  logic [7:0] ascii_i = 0, ascii_o;
`ifdef CII_CURSOR_EN
  localparam logic [7:0] C = 8'h5F, S = 8'h5F;
`else
  localparam logic [7:0] C = 8'h00, S = 8'h20;
`endif
  typedef struct {logic [6:0] x; logic [4:0] y; logic [7:0] e;} vec_t;
  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         checks = 0, errors = 0;

  cii_table_ctrl dut (
    .clk(clk), .rstn(rstn), .char_x_rd(char_x_rd), .char_y_rd(char_y_rd),
    .rd_vld(rd_vld), .we_vld(we_vld), .ascii_i(ascii_i), .ascii_o(ascii_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  task automatic check(input string nm);
    logic [7:0] e;
    e = sb.pop_front();
    checks++;
    if (ascii_o !== e) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, ascii_o, e);
    end
  endtask

  task automatic rd(input logic [6:0] x, input logic [4:0] y, input logic [7:0] e, input string nm);
    @(negedge clk);
    char_x_rd = x; char_y_rd = y; rd_vld = 1;
    sb.push_back(e);
    @(posedge clk); #1;
    check(nm);
  endtask

  task automatic add(input logic [6:0] x, input logic [4:0] y, input logic [7:0] e);
    vecs.push_back('{x, y, e});
  endtask

  task automatic run_vecs(input string nm);
    foreach (vecs[i]) rd(vecs[i].x, vecs[i].y, vecs[i].e, $sformatf("%s[%0d](%0d,%0d)", nm, i, vecs[i].x, vecs[i].y));
    vecs.delete();
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk); we_vld = 1; ascii_i = c;
    @(negedge clk); we_vld = 0;
  endtask

  task automatic reset_check(input string nm);
    @(negedge clk); rstn = 0; we_vld = 0;
    @(posedge clk); #1;
    sb.push_back(8'h00);
    check(nm);
    @(negedge clk); rstn = 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1; sb.push_back(8'h00); check("reset_init");
    @(negedge clk); rstn = 1;
    repeat (5) @(negedge clk);
    send(8'h41);
    rd(0, 0, 8'h00, "clear_rd");
    repeat (2100) @(negedge clk);
    add(0, 0, C); add(69, 29, 8'h00); add(70, 0, 8'h00); add(0, 30, 8'h00); add(127, 31, 8'h00);
    run_vecs("t1");
    send(8'h41);
    @(negedge clk); we_vld = 1; ascii_i = 8'h42;
    repeat (10) @(negedge clk);
    we_vld = 0;
    send(8'h09); send(8'h7F); send(8'h00);
    add(0, 0, 8'h41); add(1, 0, 8'h42); add(2, 0, C); add(3, 0, 8'h00);
    run_vecs("t2");
    send(8'h43); send(8'h0D);
    for (int i = 0; i < 70; i++) send(8'h61);
    send(8'h62); send(8'h0D); send(8'h63); send(8'h0A); send(8'h08);
    rd(69, 3, S, "bs_space");
    send(8'h44);
    send(8'h41); send(8'h42); send(8'h08); send(8'h43);
    add(2, 0, 8'h43); add(3, 0, 8'h00); add(0, 1, 8'h61); add(69, 1, 8'h61);
    add(0, 2, 8'h62); add(1, 2, 8'h00); add(0, 3, 8'h63); add(1, 3, 8'h00);
    add(69, 3, 8'h44); add(68, 3, 8'h00); add(0, 4, 8'h41); add(1, 4, 8'h43); add(2, 4, C);
    run_vecs("t3");
    rd(0, 1, 8'h61, "pre_hold");
    @(negedge clk); rd_vld = 0; char_x_rd = 0; char_y_rd = 0;
    repeat (2) @(posedge clk);
    #1; sb.push_back(8'h61); check("rd_hold");
    @(negedge clk);
    we_vld = 1; ascii_i = 8'h47; char_x_rd = 2; char_y_rd = 4; rd_vld = 1;
    sb.push_back(C);
    @(posedge clk); #1; check("rw_old");
    @(negedge clk); we_vld = 0;
    rd(2, 4, 8'h47, "rw_new");
    reset_check("reset_out");
    repeat (100) @(negedge clk);
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (2040) @(negedge clk);
    send(8'h41);
    rd(0, 0, 8'h00, "restart_clear_rd");
    repeat (80) @(negedge clk);
    send(8'h08);
    rd(69, 29, S, "bs_origin");
    send(8'h45); send(8'h46);
    add(69, 29, 8'h45); add(0, 0, 8'h46); add(0, 1, 8'h00); add(0, 3, 8'h00);
    add(2, 4, 8'h00); add(1, 0, C); add(68, 29, 8'h00);
    run_vecs("t4");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
